decryption_demux: RTL and testbench
===================================

# decryption_demux

Front-end router for the decryption engines. It accepts one encrypted character per cycle, with a per-character engine select. It buffers characters in a small in-order FIFO while the selected engine reports busy, and delivers each character to exactly one of three engine channels: 0 = caesar, 1 = scytale, 2 = zigzag. It sits directly upstream of the engines and drives their data_i/valid_i pairs.

## Interface
- D_WIDTH, 8, character width
- DEPTH, 4, FIFO entries; power of two, ≥2
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- data_i  in  D_WIDTH  encrypted character
- valid_i  in  1  data_i/select_i valid this cycle
- select_i  in  2  target engine: 0..2; 3 = invalid
- busy  out  1  FIFO full; upstream must not assert valid_i while high
- data0_o / data1_o / data2_o  out  D_WIDTH  character to engine 0/1/2
- valid0_o / valid1_o / valid2_o  out  1  character valid to engine 0/1/2
- busy0_i / busy1_i / busy2_i  in  1  engine 0/1/2 cannot accept this cycle

## Operation
- Storage: FIFO of DEPTH entries, each {select, data}.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - count is log2(DEPTH)+1 bits.
- Input accept, at an edge: requires valid_i=1 and select_i≠3, and either count<DEPTH or a pop at the same edge.
  - select_i=3: character dropped silently; no state change.
  - Write while full with no pop: dropped.
- Emission: at most one character per edge, strictly in arrival order.
  - Pop: FIFO non-empty and busyN_i of the head's target is low. Head goes to channel N.
  - Bypass: FIFO empty, an accepted input, and its target's busy_i low. Input goes straight to its channel and is not written.
  - Otherwise an accepted input is written to the tail.
- Simultaneous pop and write are allowed; count is unchanged.
- Head blocked by a busy engine:
  - Nothing is emitted.
  - Later characters for idle engines wait behind it (head-of-line blocking is intended).
- Outputs are registered.
  - Emitting channel: validN_o=1, dataN_o=character.
  - Every non-emitting channel: validN_o=0, dataN_o=0.
- busy is registered: busy <= (count_next == DEPTH).
- Reset (asynchronous, any time, including mid-stream):
  - FIFO emptied, pointers and count = 0.
  - All validN_o=0, all dataN_o=0, busy=0.

## Timing
- Latency with empty FIFO and idle target: character sampled at edge N; validN_o/dataN_o high during cycle N+1 (one cycle, same as the engines).
- Buffered character: emitted at the first edge where it is head and its engine's busy_i is low; visible the following cycle.
- Throughput: one character per cycle when targets are idle.
- busy timing:
  - Rises the cycle after the write that fills the FIFO.
  - Falls the cycle after the first pop from full.
- busy_i is sampled at the emitting edge; an engine raising busy_i blocks emission at that same edge.
- Wrap-around: read and write pointers wrap from DEPTH-1 to 0 with no bubble.

## Configuration
- DECRYPTION_DEMUX_OVERFLOW_EN defined:
  - Adds output port overflow (1 bit), reset 0.
  - Sets and stays set (sticky until reset) on any edge where valid_i=1, select_i≠3 and the character is dropped because the FIFO is full.
  - Also sets on select_i=3 with valid_i=1.
- Not defined: port absent; drops are silent. All other behaviour is identical.

## Test plan
- Bypass: FIFO empty, all busy low; valid_i=1, select_i=0, data_i=8'h41 at edge 1 -> cycle 2: valid0_o=1, data0_o=8'h41, valid1_o=valid2_o=0 with data 0; cycle 3: all valid low.
- Blocking and order:
  - Stimulus: busy1_i=1; send 'A','B','C' to select 1, then 'D' to select 0; release busy1_i after 5 cycles.
  - Response: nothing emitted while busy; then A, B, C on channel 1 and D on channel 0 on consecutive cycles.
- Full/busy with DEPTH=4:
  - Stimulus: busy2_i=1; send 4 chars to select 2.
  - Response: busy=1 the cycle after the 4th write.
  - Stimulus: a 5th char with valid_i=1 anyway.
  - Response: dropped (overflow=1 with macro).
  - Stimulus: release busy2_i.
  - Response: exactly 4 chars emitted; busy falls the cycle after the first pop.
- Simultaneous push/pop at full: FIFO full, head target idle, new valid input -> pop and write at the same edge, count stays 4, no drop; pointers wrap cleanly over 3 fills.
- Invalid select: select_i=3, valid_i=1 -> no output on any channel, count unchanged.
- Reset mid-stream: rst_n low asynchronously with 3 entries buffered and valid1_o high -> all outputs 0 and busy 0 immediately; after release, no stale characters are emitted.

Source files
------------

// File: rtl/decryption_demux.sv
// Routes encrypted characters to the caesar/scytale/zigzag engines through a small in-order FIFO.
// Optional sticky drop flag on port overflow when DECRYPTION_DEMUX_OVERFLOW_EN is defined.
module decryption_demux #(
  parameter int unsigned D_WIDTH = 8,
  parameter int unsigned DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [D_WIDTH-1:0] data_i,
  input  logic               valid_i,
  input  logic [1:0]         select_i,
  output logic               busy,
`ifdef DECRYPTION_DEMUX_OVERFLOW_EN
  output logic               overflow,
`endif
  output logic [D_WIDTH-1:0] data0_o,
  output logic [D_WIDTH-1:0] data1_o,
  output logic [D_WIDTH-1:0] data2_o,
  output logic               valid0_o,
  output logic               valid1_o,
  output logic               valid2_o,
  input  logic               busy0_i,
  input  logic               busy1_i,
  input  logic               busy2_i
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [1:0]         sel;
    logic [D_WIDTH-1:0] data;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_next;

  entry_t             head;
  entry_t             in_ent;
  entry_t             emit_ent;
  logic               in_ok;
  logic               empty;
  logic               full;
  logic               pop;
  logic               bypass;
  logic               accept;
  logic               write;
  logic               emit;
  logic               drop;

  // Engine busy for a given target; the unused code 3 never reaches the FIFO.
  function automatic logic sel_busy(input logic [1:0] sel, input logic b0, input logic b1,
                                    input logic b2);
    logic r;
    r = 1'b1;
    case (sel)
      2'd0:    r = b0;
      2'd1:    r = b1;
      2'd2:    r = b2;
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  // Accept / pop / bypass decision for the coming edge.
  always_comb begin
    head       = mem[rd_ptr];
    in_ent     = '{sel: select_i, data: data_i};
    empty      = (count == '0);
    full       = (count == CNT_W'(DEPTH));
    in_ok      = valid_i && (select_i != 2'd3);
    pop        = !empty && !sel_busy(head.sel, busy0_i, busy1_i, busy2_i);
    accept     = in_ok && (!full || pop);
    bypass     = empty && accept && !sel_busy(select_i, busy0_i, busy1_i, busy2_i);
    write      = accept && !bypass;
    emit       = pop || bypass;
    emit_ent   = pop ? head : in_ent;
    drop       = valid_i && !accept;
    count_next = count + CNT_W'(write) - CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      busy   <= 1'b0;
    end else begin
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      if (write) wr_ptr <= wr_ptr + PTR_W'(1);
      count <= count_next;
      busy  <= (count_next == CNT_W'(DEPTH));
    end
  end

  // Storage needs no reset: entries are only read once the count covers them.
  always_ff @(posedge clk) begin
    if (write) mem[wr_ptr] <= in_ent;
  end

  // Exactly one channel (or none) carries a character; idle channels read zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid0_o <= 1'b0;
      valid1_o <= 1'b0;
      valid2_o <= 1'b0;
      data0_o  <= '0;
      data1_o  <= '0;
      data2_o  <= '0;
    end else begin
      valid0_o <= emit && (emit_ent.sel == 2'd0);
      valid1_o <= emit && (emit_ent.sel == 2'd1);
      valid2_o <= emit && (emit_ent.sel == 2'd2);
      data0_o  <= (emit && (emit_ent.sel == 2'd0)) ? emit_ent.data : '0;
      data1_o  <= (emit && (emit_ent.sel == 2'd1)) ? emit_ent.data : '0;
      data2_o  <= (emit && (emit_ent.sel == 2'd2)) ? emit_ent.data : '0;
    end
  end

`ifdef DECRYPTION_DEMUX_OVERFLOW_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    overflow <= 1'b0;
    else if (drop) overflow <= 1'b1;
  end
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_decryption_demux.sv
// Scoreboard bench for decryption_demux: queue-based reference model, cycle-stamped expectations.
// Connects the overflow port when DECRYPTION_DEMUX_OVERFLOW_EN is defined.
module tb_decryption_demux;

  localparam int DEPTH = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] data_i;
  logic       valid_i;
  logic [1:0] select_i;
  logic       busy;
  logic [7:0] data0_o, data1_o, data2_o;
  logic       valid0_o, valid1_o, valid2_o;
  logic       busy0_i, busy1_i, busy2_i;
`ifdef DECRYPTION_DEMUX_OVERFLOW_EN
  logic       overflow;
`endif

  decryption_demux #(.D_WIDTH(8), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .data_i(data_i), .valid_i(valid_i), .select_i(select_i),
    .busy(busy),
`ifdef DECRYPTION_DEMUX_OVERFLOW_EN
    .overflow(overflow),
`endif
    .data0_o(data0_o), .data1_o(data1_o), .data2_o(data2_o),
    .valid0_o(valid0_o), .valid1_o(valid1_o), .valid2_o(valid2_o),
    .busy0_i(busy0_i), .busy1_i(busy1_i), .busy2_i(busy2_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         sel;
    logic [7:0] data;
  } ent_t;

  typedef struct {
    int         chan;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  ent_t fifo_q[$];
  exp_t exp_q[$];
  logic exp_busy;
  logic exp_ovf;
  int   cyc;
  int   checks;
  int   errors;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: decides what the upcoming edge does with the inputs just driven.
  task automatic model(input logic v, input int s, input logic [7:0] d, input logic [2:0] b);
    bit was_empty;
    bit popped;
    ent_t e;
    was_empty = (fifo_q.size() == 0);
    popped = 0;
    if (!was_empty && !b[fifo_q[0].sel]) begin
      e = fifo_q.pop_front();
      exp_q.push_back('{chan: e.sel, data: e.data, cyc: cyc + 1});
      popped = 1;
    end
    if (v && s != 3) begin
      if (fifo_q.size() >= DEPTH) exp_ovf = 1'b1;
      else if (was_empty && !b[s]) exp_q.push_back('{chan: s, data: d, cyc: cyc + 1});
      else fifo_q.push_back('{sel: s, data: d});
    end else if (v) begin
      exp_ovf = 1'b1;
    end
    exp_busy = (fifo_q.size() == DEPTH);
  endtask

  task automatic step(input logic v, input int s, input logic [7:0] d, input logic [2:0] b);
    @(negedge clk);
    #1;
    valid_i  = v;
    select_i = 2'(s);
    data_i   = d;
    {busy2_i, busy1_i, busy0_i} = b;
    model(v, s, d, b);
  endtask

  task automatic idle(input int n, input logic [2:0] b);
    for (int i = 0; i < n; i++) step(1'b0, 0, 8'h00, b);
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if ({valid2_o, valid1_o, valid0_o, data2_o, data1_o, data0_o, busy} !== '0) begin
      errors++;
      $display("FAIL %s: got v=%b d=%h/%h/%h busy=%b, want all zero", name,
               {valid2_o, valid1_o, valid0_o}, data2_o, data1_o, data0_o, busy);
    end
`ifdef DECRYPTION_DEMUX_OVERFLOW_EN
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL %s_overflow: got %b want 0", name, overflow);
    end
`endif
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    valid_i = 1'b0;
    #1;
    check_reset_outputs(name);
    fifo_q.delete();
    exp_q.delete();
    exp_busy = 1'b0;
    exp_ovf  = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Monitor: compares every cycle's outputs against the stamped expectation.
  logic [2:0] m_v;
  logic [7:0] m_d [3];
  exp_t       m_e;
  always @(negedge clk) begin
    if (rst_n) begin
      m_v = '0;
      m_d[0] = '0; m_d[1] = '0; m_d[2] = '0;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        m_e = exp_q.pop_front();
        m_v[m_e.chan] = 1'b1;
        m_d[m_e.chan] = m_e.data;
      end
      checks++;
      if ({valid2_o, valid1_o, valid0_o, data2_o, data1_o, data0_o} !==
          {m_v, m_d[2], m_d[1], m_d[0]}) begin
        errors++;
        $display("FAIL out cyc=%0d: got v=%b d=%h/%h/%h want v=%b d=%h/%h/%h", cyc,
                 {valid2_o, valid1_o, valid0_o}, data2_o, data1_o, data0_o,
                 m_v, m_d[2], m_d[1], m_d[0]);
      end
      checks++;
      if (busy !== exp_busy) begin
        errors++;
        $display("FAIL busy cyc=%0d: got %b want %b", cyc, busy, exp_busy);
      end
`ifdef DECRYPTION_DEMUX_OVERFLOW_EN
      checks++;
      if (overflow !== exp_ovf) begin
        errors++;
        $display("FAIL overflow cyc=%0d: got %b want %b", cyc, overflow, exp_ovf);
      end
`endif
    end
  end

  initial begin
    cyc = 0; checks = 0; errors = 0;
    exp_busy = 1'b0; exp_ovf = 1'b0;
    rst_n = 1'b1; valid_i = 1'b0; select_i = 2'd0; data_i = 8'h00;
    busy0_i = 1'b0; busy1_i = 1'b0; busy2_i = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset_init");
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Bypass to caesar
    step(1'b1, 0, 8'h41, 3'b000);
    idle(2, 3'b000);

    // Head-of-line blocking on scytale, then in-order release
    step(1'b1, 1, 8'h41, 3'b010);
    step(1'b1, 1, 8'h42, 3'b010);
    step(1'b1, 1, 8'h43, 3'b010);
    step(1'b1, 0, 8'h44, 3'b010);
    idle(1, 3'b010);
    idle(6, 3'b000);

    // Fill to full on zigzag, overrun, then drain
    for (int i = 0; i < 4; i++) step(1'b1, 2, 8'h60 + 8'(i), 3'b100);
    step(1'b1, 2, 8'h6f, 3'b100);
    idle(2, 3'b100);
    idle(6, 3'b000);

    // Push and pop together at full across several pointer wraps
    for (int i = 0; i < 4; i++) step(1'b1, 2, 8'h80 + 8'(i), 3'b100);
    for (int i = 0; i < 12; i++) step(1'b1, $urandom_range(0, 2), 8'($urandom), 3'b000);
    idle(6, 3'b000);

    // Invalid target select
    step(1'b1, 3, 8'h99, 3'b000);
    idle(2, 3'b000);

    // Reset with three buffered entries and scytale output active
    do_reset("reset_clear");
    step(1'b1, 1, 8'h31, 3'b010);
    step(1'b1, 0, 8'h32, 3'b011);
    step(1'b1, 0, 8'h33, 3'b011);
    step(1'b1, 0, 8'h34, 3'b001);
    do_reset("reset_mid");
    idle(6, 3'b000);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic       v;
      int         s;
      logic [2:0] b;
      v = ($urandom_range(0, 3) != 0);
      if (busy && $urandom_range(0, 3) != 0) v = 1'b0;
      s = ($urandom_range(0, 15) == 0) ? 3 : int'($urandom_range(0, 2));
      b[0] = ($urandom_range(0, 9) < 3);
      b[1] = ($urandom_range(0, 9) < 3);
      b[2] = ($urandom_range(0, 9) < 3);
      step(v, s, 8'($urandom), b);
    end
    idle(DEPTH + 4, 3'b000);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0 || fifo_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, %0d model entries, want 0",
               exp_q.size(), fifo_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
